// File: rtl/streetlight_pkg.sv
// Shared types and helpers for the street-light array controller.
// Lamp state codes and the state-to-duty mapping used by every lamp channel.
package streetlight_pkg;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        DIM    = 2'd1,
        BRIGHT = 2'd2,
        HOLD   = 2'd3
    } lamp_state_t;

    function automatic int unsigned duty_of(lamp_state_t s, int unsigned dim_duty,
                                            int unsigned bright_duty);
        case (s)
            DIM:          return dim_duty;
            BRIGHT, HOLD: return bright_duty;
            default:      return 0;
        endcase
    endfunction

endpackage

// File: rtl/streetlight_lamp_ch.sv
// One lamp channel: off/dim/bright/hold FSM, post-vehicle hold timer and PWM compare flop.
// With STREETLIGHT_RAMP_EN defined, duty ramps toward the target once per PWM period.
module streetlight_lamp_ch
    import streetlight_pkg::*;
#(
    parameter int PWM_W       = 8,
    parameter int DIM_DUTY    = 64,
    parameter int BRIGHT_DUTY = 255,
    parameter int HOLD_CYCLES = 1000,
    parameter int RAMP_STEP   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              day_filt_i,
    input  logic              want_i,
    input  logic [PWM_W-1:0]  pwm_cnt_i,
    output logic              pwm_o,
    output lamp_state_t       state_o
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    lamp_state_t       state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [PWM_W-1:0]  target;
    logic [PWM_W-1:0]  duty;
    logic              pwm_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        if (day_filt_i) begin
            state_d = OFF;
            hold_d  = '0;
        end else begin
            case (state_q)
                OFF:    state_d = DIM;
                DIM:    if (want_i) state_d = BRIGHT;
                BRIGHT: begin
                    if (!want_i) begin
                        state_d = HOLD;
                        hold_d  = HOLD_LOAD;
                    end
                end
                HOLD: begin
                    if (want_i)             state_d = BRIGHT;
                    else if (hold_q == '0)  state_d = DIM;
                    else                    hold_d  = hold_q - 1'b1;
                end
                default: state_d = OFF;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= OFF;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    assign target = PWM_W'(duty_of(state_q, DIM_DUTY, BRIGHT_DUTY));

`ifdef STREETLIGHT_RAMP_EN
    localparam logic [PWM_W:0] STEP = (PWM_W + 1)'(RAMP_STEP);

    logic [PWM_W-1:0] duty_q, duty_d;
    logic             period_end;

    // Duty only moves on the edge where the shared counter wraps to 0.
    assign period_end = (pwm_cnt_i == '1);

    always_comb begin
        duty_d = duty_q;
        if (day_filt_i) begin
            duty_d = '0;
        end else if (period_end) begin
            if (duty_q < target)
                duty_d = ({1'b0, target - duty_q} > STEP) ? duty_q + STEP[PWM_W-1:0] : target;
            else if (duty_q > target)
                duty_d = ({1'b0, duty_q - target} > STEP) ? duty_q - STEP[PWM_W-1:0] : target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) duty_q <= '0;
        else     duty_q <= duty_d;
    end

    assign duty = duty_q;
`else
    logic unused_ramp_step;
    assign unused_ramp_step = (RAMP_STEP != 0);
    assign duty = target;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pwm_q <= 1'b0;
        else     pwm_q <= (pwm_cnt_i < duty);
    end

    assign pwm_o   = pwm_q;
    assign state_o = state_q;

endmodule

// File: rtl/streetlight_array_ctrl.sv
// Street-light array: day sensor sync/debounce, shared PWM counter, neighbour look-ahead.
// Optional duty ramping per lamp is enabled by defining STREETLIGHT_RAMP_EN.
module streetlight_array_ctrl
    import streetlight_pkg::*;
#(
    parameter int NUM_LAMPS    = 4,
    parameter int PWM_W        = 8,
    parameter int DIM_DUTY     = 64,
    parameter int BRIGHT_DUTY  = 255,
    parameter int HOLD_CYCLES  = 1000,
    parameter int DAY_DEBOUNCE = 16,
    parameter int RAMP_STEP    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   day,
    input  logic [NUM_LAMPS-1:0]   veh_detect,
    output logic [NUM_LAMPS-1:0]   pwm_out,
    output logic [2*NUM_LAMPS-1:0] lamp_state,
    output logic                   day_filt
);

    localparam int DEB_W = (DAY_DEBOUNCE > 1) ? $clog2(DAY_DEBOUNCE) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DAY_DEBOUNCE - 1);

    logic                 day_s1_q, day_s2_q;
    logic [DEB_W-1:0]     deb_cnt_q, deb_cnt_d;
    logic                 day_filt_q, day_filt_d;
    logic [PWM_W-1:0]     pwm_cnt_q;
    logic [NUM_LAMPS-1:0] want;
    lamp_state_t          lamp_st [NUM_LAMPS];

    // Counter tracks how long the synchronised input has disagreed with the filtered flag.
    always_comb begin
        deb_cnt_d  = '0;
        day_filt_d = day_filt_q;
        if (day_s2_q != day_filt_q) begin
            if (deb_cnt_q == DEB_LAST) day_filt_d = ~day_filt_q;
            else                       deb_cnt_d  = deb_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            day_s1_q   <= 1'b1;
            day_s2_q   <= 1'b1;
            deb_cnt_q  <= '0;
            day_filt_q <= 1'b1;
            pwm_cnt_q  <= '0;
        end else begin
            day_s1_q   <= day;
            day_s2_q   <= day_s1_q;
            deb_cnt_q  <= deb_cnt_d;
            day_filt_q <= day_filt_d;
            pwm_cnt_q  <= pwm_cnt_q + 1'b1;
        end
    end

    // A vehicle at lamp i-1 also brightens lamp i, lighting the road ahead.
    always_comb begin
        want[0] = veh_detect[0];
        for (int i = 1; i < NUM_LAMPS; i++)
            want[i] = veh_detect[i] | veh_detect[i-1];
    end

    for (genvar g = 0; g < NUM_LAMPS; g++) begin : g_lamp
        streetlight_lamp_ch #(
            .PWM_W       (PWM_W),
            .DIM_DUTY    (DIM_DUTY),
            .BRIGHT_DUTY (BRIGHT_DUTY),
            .HOLD_CYCLES (HOLD_CYCLES),
            .RAMP_STEP   (RAMP_STEP)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .day_filt_i (day_filt_q),
            .want_i     (want[g]),
            .pwm_cnt_i  (pwm_cnt_q),
            .pwm_o      (pwm_out[g]),
            .state_o    (lamp_st[g])
        );
        assign lamp_state[2*g +: 2] = lamp_st[g];
    end

    assign day_filt = day_filt_q;

endmodule

// File: tb/tb_streetlight_array_ctrl.sv
// Self-checking bench for streetlight_array_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the lamp array.
module tb_streetlight_array_ctrl;

    localparam int N        = 4;
    localparam int HOLD_N   = 8;
    localparam int DEB      = 16;
    localparam int DIM_D    = 64;
    localparam int BRIGHT_D = 255;
    localparam int STEP     = 64;
    localparam int PMAX     = 255;

    logic         clk;
    logic         rst;
    logic         day;
    logic [N-1:0] veh_detect;
    logic [N-1:0] pwm_out;
    logic [2*N-1:0] lamp_state;
    logic         day_filt;

    int checks = 0;
    int errors = 0;

    streetlight_array_ctrl #(
        .NUM_LAMPS    (N),
        .PWM_W        (8),
        .DIM_DUTY     (DIM_D),
        .BRIGHT_DUTY  (BRIGHT_D),
        .HOLD_CYCLES  (HOLD_N),
        .DAY_DEBOUNCE (DEB),
        .RAMP_STEP    (STEP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .day        (day),
        .veh_detect (veh_detect),
        .pwm_out    (pwm_out),
        .lamp_state (lamp_state),
        .day_filt   (day_filt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: 0 off, 1 dim, 2 bright, 3 hold; hold exit timed by cycle stamps.
    int  m_state [N];
    int  m_enter [N];
    int  m_duty  [N];
    bit  m_pwm   [N];
    bit  m_s1, m_s2, m_filt;
    int  m_run, m_cnt, m_t;

    function automatic int target_of(int s);
        if (s == 1) return DIM_D;
        if (s >= 2) return BRIGHT_D;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_state[i] = 0; m_enter[i] = 0; m_duty[i] = 0; m_pwm[i] = 0;
        end
        m_s1 = 1; m_s2 = 1; m_filt = 1; m_run = 0; m_cnt = 0; m_t = 0;
    endtask

    task automatic model_step();
        bit want [N];
        int t;
        for (int i = 0; i < N; i++)
            want[i] = veh_detect[i] | ((i > 0) ? veh_detect[i-1] : 1'b0);
        for (int i = 0; i < N; i++) begin
`ifdef STREETLIGHT_RAMP_EN
            m_pwm[i] = (m_cnt < m_duty[i]);
            t = target_of(m_state[i]);
            if (m_filt) m_duty[i] = 0;
            else if (m_cnt == PMAX) begin
                if (m_duty[i] < t)      m_duty[i] = (m_duty[i] + STEP > t) ? t : m_duty[i] + STEP;
                else if (m_duty[i] > t) m_duty[i] = (m_duty[i] - STEP < t) ? t : m_duty[i] - STEP;
            end
`else
            t = target_of(m_state[i]);
            m_pwm[i] = (m_cnt < t);
`endif
            if (m_filt) m_state[i] = 0;
            else if (m_state[i] == 0) m_state[i] = 1;
            else if (m_state[i] == 1) begin
                if (want[i]) m_state[i] = 2;
            end else if (m_state[i] == 2) begin
                if (!want[i]) begin m_state[i] = 3; m_enter[i] = m_t; end
            end else begin
                if (want[i]) m_state[i] = 2;
                else if (m_t - m_enter[i] >= HOLD_N) m_state[i] = 1;
            end
        end
        if (m_s2 != m_filt) begin
            if (m_run == DEB - 1) begin m_filt = ~m_filt; m_run = 0; end
            else m_run++;
        end else m_run = 0;
        m_s2 = m_s1;
        m_s1 = day;
        m_cnt = (m_cnt + 1) % (PMAX + 1);
        m_t++;
    endtask

    function automatic logic [2*N+N:0] model_vec();
        logic [2*N-1:0] s;
        logic [N-1:0]   p;
        for (int i = 0; i < N; i++) begin
            s[2*i +: 2] = 2'(m_state[i]);
            p[i]        = m_pwm[i];
        end
        return {s, p, m_filt};
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; day = 1'b1; veh_detect = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({lamp_state, pwm_out, day_filt} !== {8'h00, 4'h0, 1'b1}) begin
            errors++;
            $display("FAIL reset_values got %h want %h", {lamp_state, pwm_out, day_filt}, {8'h00, 4'h0, 1'b1});
        end
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if ({lamp_state, pwm_out, day_filt} !== model_vec() || lamp_state !== 8'h00) begin
                errors++;
                $display("FAIL reset_day_hold got %h want %h", {lamp_state, pwm_out, day_filt}, model_vec());
            end
        end
    endtask

    task automatic test_day_glitch();
        day = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (k == 10) day = 1'b1;
            tick();
            checks++;
            if ({lamp_state, pwm_out, day_filt} !== model_vec()) begin
                errors++;
                $display("FAIL glitch_model got %h want %h", {lamp_state, pwm_out, day_filt}, model_vec());
            end
        end
        checks++;
        if (day_filt !== 1'b1 || lamp_state !== 8'h00) begin
            errors++;
            $display("FAIL glitch_ignored got filt=%b state=%h want filt=1 state=00", day_filt, lamp_state);
        end
    endtask

    task automatic test_day_fall();
        int fall_at;
        int highs [N];
        fall_at = -1;
        day = 1'b0;
        for (int k = 1; k <= 40 && fall_at < 0; k++) begin
            tick();
            checks++;
            if ({lamp_state, pwm_out, day_filt} !== model_vec()) begin
                errors++;
                $display("FAIL fall_model got %h want %h", {lamp_state, pwm_out, day_filt}, model_vec());
            end
            if (day_filt === 1'b0) fall_at = k;
        end
        checks++;
        if (fall_at != DEB + 2) begin
            errors++;
            $display("FAIL day_fall_latency got %0d want %0d (-1 = timeout)", fall_at, DEB + 2);
        end
        tick();
        checks++;
        if (lamp_state !== 8'h55) begin
            errors++;
            $display("FAIL night_all_dim got %h want 55", lamp_state);
        end
`ifndef STREETLIGHT_RAMP_EN
        tick();
        for (int i = 0; i < N; i++) highs[i] = 0;
        for (int k = 0; k < PMAX + 1; k++) begin
            tick();
            for (int i = 0; i < N; i++) highs[i] += int'(pwm_out[i]);
            checks++;
            if ({lamp_state, pwm_out, day_filt} !== model_vec()) begin
                errors++;
                $display("FAIL dim_pwm_model got %h want %h", {lamp_state, pwm_out, day_filt}, model_vec());
            end
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (highs[i] != DIM_D) begin
                errors++;
                $display("FAIL dim_duty_lamp%0d got %0d high want %0d", i, highs[i], DIM_D);
            end
        end
`endif
    endtask

    task automatic test_vehicle();
        logic [7:0] exp_st;
        veh_detect = 4'b0010;
        for (int k = 1; k <= 14; k++) begin
            if (k == 6) veh_detect = '0;
            tick();
            exp_st = (k <= 5) ? 8'h69 : (k <= 13) ? 8'h7D : 8'h55;
            checks++;
            if (lamp_state !== exp_st || {lamp_state, pwm_out, day_filt} !== model_vec()) begin
                errors++;
                $display("FAIL vehicle_hold k=%0d got %h want state %h model %h", k, {lamp_state, pwm_out, day_filt}, exp_st, model_vec());
            end
        end
    endtask

    task automatic test_rearrival();
        logic [7:0] exp_st;
        veh_detect = 4'b0001;
        for (int k = 1; k <= 18; k++) begin
            if (k == 4) veh_detect = '0;
            if (k == 8) veh_detect = 4'b0001;
            if (k == 10) veh_detect = '0;
            tick();
            if (k <= 3 || k == 8 || k == 9) exp_st = 8'h5A;
            else if (k <= 7 || k <= 17)     exp_st = 8'h5F;
            else                            exp_st = 8'h55;
            checks++;
            if (lamp_state !== exp_st || {lamp_state, pwm_out, day_filt} !== model_vec()) begin
                errors++;
                $display("FAIL rearrival k=%0d got %h want state %h model %h", k, {lamp_state, pwm_out, day_filt}, exp_st, model_vec());
            end
        end
    endtask

    task automatic test_day_rise_in_hold();
        int rise_at;
        rise_at = -1;
        day = 1'b1;
        veh_detect = 4'b0100;
        for (int k = 1; k <= 40 && rise_at < 0; k++) begin
            if (k == 13) veh_detect = '0;
            tick();
            checks++;
            if ({lamp_state, pwm_out, day_filt} !== model_vec()) begin
                errors++;
                $display("FAIL rise_model got %h want %h", {lamp_state, pwm_out, day_filt}, model_vec());
            end
            if (day_filt === 1'b1) rise_at = k;
        end
        checks++;
        if (rise_at != DEB + 2 || lamp_state[5:4] !== 2'd3) begin
            errors++;
            $display("FAIL rise_during_hold got at=%0d lamp2=%0d want at=%0d lamp2=3", rise_at, lamp_state[5:4], DEB + 2);
        end
        tick();
        checks++;
        if (lamp_state !== 8'h00) begin
            errors++;
            $display("FAIL rise_all_off got %h want 00", lamp_state);
        end
        tick();
        checks++;
        if (pwm_out !== 4'h0) begin
            errors++;
            $display("FAIL rise_pwm_low got %b want 0000", pwm_out);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(7) == 0) veh_detect = N'($urandom);
            if ($urandom_range(149) == 0) day = ~day;
            tick();
            checks++;
            if ({lamp_state, pwm_out, day_filt} !== model_vec()) begin
                errors++;
                $display("FAIL random_model k=%0d got %h want %h", k, {lamp_state, pwm_out, day_filt}, model_vec());
            end
        end
    endtask

`ifdef STREETLIGHT_RAMP_EN
    task automatic test_ramp();
        int highs;
        int exp_high [4];
        exp_high[0] = 64; exp_high[1] = 128; exp_high[2] = 192; exp_high[3] = 255;
        day = 1'b0; veh_detect = '0;
        repeat (600) tick();
        for (int k = 0; k < 300 && m_cnt != 0; k++) tick();
        veh_detect = 4'b1000;
        for (int p = 0; p < 4; p++) begin
            highs = 0;
            for (int k = 0; k < PMAX + 1; k++) begin
                tick();
                highs += int'(pwm_out[3]);
                checks++;
                if ({lamp_state, pwm_out, day_filt} !== model_vec()) begin
                    errors++;
                    $display("FAIL ramp_model got %h want %h", {lamp_state, pwm_out, day_filt}, model_vec());
                end
            end
            checks++;
            if (highs != exp_high[p]) begin
                errors++;
                $display("FAIL ramp_period%0d got %0d high want %0d", p, highs, exp_high[p]);
            end
        end
        repeat (100) tick();
        rst = 1'b1;
        #1;
        checks++;
        if ({lamp_state, pwm_out, day_filt} !== {8'h00, 4'h0, 1'b1}) begin
            errors++;
            $display("FAIL async_reset got %h want %h", {lamp_state, pwm_out, day_filt}, {8'h00, 4'h0, 1'b1});
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_day_glitch();
        test_day_fall();
        test_vehicle();
        test_rearrival();
        test_day_rise_in_hold();
        test_random();
`ifdef STREETLIGHT_RAMP_EN
        test_ramp();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/streetlight_array_ctrl.md
Name: streetlight_array_ctrl

Overview:
- Parametrised successor to the single-lamp off/dim/bright controller; drives NUM_LAMPS lamps along a road segment.
- Each lamp has its own state machine and a post-vehicle hold timer.
- Each lamp has a PWM brightness output in place of one-hot colour outputs.
- A shared debounced day sensor and neighbour look-ahead (vehicle at lamp i also brightens lamp i+1) are added.
- Sits between the sensor front-end and the lamp driver pads.

Parameters:
- NUM_LAMPS, 4, number of lamp channels (>=1)
- PWM_W, 8, PWM counter / duty width
- DIM_DUTY, 64, duty code in DIM (< 2^PWM_W)
- BRIGHT_DUTY, 255, duty code in BRIGHT/HOLD (< 2^PWM_W, >= DIM_DUTY)
- HOLD_CYCLES, 1000, cycles a lamp stays bright after its vehicle input drops (>=1)
- DAY_DEBOUNCE, 16, consecutive equal samples required to change the filtered day flag (>=1)
- RAMP_STEP, 4, duty increment per PWM period (used only with ramp feature)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- day  in  1  raw ambient-light sensor (1 = daylight), asynchronous to design; double-flop synchronised inside
- veh_detect  in  NUM_LAMPS  per-lamp vehicle sensor, synchronous to clk
- pwm_out  out  NUM_LAMPS  per-lamp PWM drive, registered
- lamp_state  out  2*NUM_LAMPS  per-lamp state code, lamp i at [2i+1:2i]
- day_filt  out  1  debounced day flag

Behaviour:
- Reset: day_filt=1, all lamp_state=OFF, pwm_out=0, PWM counter=0, hold counters=0, debounce counter=0, synchroniser flops=1. Async assertion; deassertion takes effect at the next clk edge.
- Day filter:
  - Synchronised day is compared to day_filt.
  - When they differ, a counter increments; when equal, it clears.
  - When the counter reaches DAY_DEBOUNCE-1 while they still differ, day_filt toggles on that edge.
  - Latency from a stable raw change: 2 sync cycles + DAY_DEBOUNCE cycles.
- Effective demand: want[i] = veh_detect[i] | veh_detect[i-1] (for i=0 only veh_detect[0]).
- State codes: OFF=0, DIM=1, BRIGHT=2, HOLD=3. Transitions per lamp, priority top-down:
  - day_filt=1: any state -> OFF, hold counter cleared.
  - OFF: -> DIM.
  - DIM: want -> BRIGHT, else stay.
  - BRIGHT: !want -> HOLD, hold counter loaded HOLD_CYCLES-1; else stay.
  - HOLD: want -> BRIGHT; else if counter==0 -> DIM; else decrement.
- Hold timing: for HOLD_CYCLES=N, the lamp is in HOLD for exactly N cycles before DIM. Vehicle re-arrival during HOLD returns to BRIGHT next cycle, and the counter reloads on the next exit from BRIGHT.
- Duty target: OFF=0, DIM=DIM_DUTY, BRIGHT/HOLD=BRIGHT_DUTY.
- PWM:
  - Single shared free-running PWM_W-bit counter, wraps 2^PWM_W-1 -> 0.
  - pwm_out[i] is registered (cnt < duty[i]), so duty 0 gives a constant low.
  - Duty 2^PWM_W-1 gives low for one count per period.
  - One-cycle latency from counter to output.
  - Without ramp, duty equals the target immediately, so a state change is visible on pwm_out within 2 cycles.
- Simultaneous events:
  - day_filt rising wins over want.
  - want and hold-expiry in the same cycle go to BRIGHT.
- An illegal state code recovers to OFF.

Optional Feature:
- Macro: STREETLIGHT_RAMP_EN.
- Defined:
  - Each lamp holds a registered duty that moves toward the target by RAMP_STEP once per PWM period, when the counter wraps to 0.
  - Moves are saturating, never overshooting the target.
  - Entering OFF because day_filt=1 forces duty to 0 immediately.
  - Duty updates only at period boundaries, so there are no partial-period glitches.
- Undefined: duty = target combinationally from state; no ramp registers; RAMP_STEP is ignored.

Decomposition:
- Package streetlight_pkg:
  - lamp_state_t enum (OFF, DIM, BRIGHT, HOLD, 2 bits)
  - duty-selection function mapping state to duty
- Sub-module streetlight_lamp_ch, one per lamp via generate. Contains:
  - FSM
  - hold counter
  - ramp register (when enabled)
  - PWM compare flop
- Top module contains: day synchroniser/debouncer, shared PWM counter, want[] neighbour logic.

Test Plan:
- Reset then day=1 held: lamp_state all OFF, pwm_out all 0, day_filt=1. Drop day to 0 for 20 cycles (DAY_DEBOUNCE=16): day_filt falls at cycle 18 after the change; all lamps DIM the next cycle. pwm_out[i] is high for 64 of every 256 cycles.
- Day glitch: day low for 10 cycles then high: day_filt stays 1, lamps stay OFF.
- Night, pulse veh_detect[1]=1 for 5 cycles with HOLD_CYCLES=8:
  - lamps 1 and 2 go BRIGHT one cycle after assertion; lamps 0 and 3 stay DIM.
  - after the drop, lamps 1 and 2 sit in HOLD for exactly 8 cycles, then DIM.
- Re-arrival: veh_detect[0] reasserted on the 4th HOLD cycle: lamp 0 returns to BRIGHT next cycle. A later drop gives the full 8-cycle HOLD again.
- Day rises while lamp 2 is in HOLD: once day_filt=1, all lamps OFF in one cycle and pwm_out is 0 from the next PWM compare.
- With STREETLIGHT_RAMP_EN and RAMP_STEP=64, DIM->BRIGHT: duty steps 64 -> 128 -> 192 -> 255 on three successive period boundaries. A mid-period rst forces pwm_out=0 asynchronously.
